// File: rtl/noekeon_data_buffer.sv
// Noekeon cipher state register with prioritised parallel writes plus
// word-serial load and unload paths, each with a valid/ready handshake.
module noekeon_data_buffer #(
  parameter  int DATA_W    = 128,
  parameter  int WORD_W    = 32,
  localparam int NUM_WORDS = DATA_W / WORD_W,
  localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              inClk,
  input  logic              inResetN,
  input  logic              inDataWrKey,
  input  logic [DATA_W-1:0] inDataDataKey,
  input  logic              inDataWrExt,
  input  logic [DATA_W-1:0] inDataDataExt,
  input  logic              inDataWrInt,
  input  logic [DATA_W-1:0] inDataDataInt,
  input  logic              inLoadValid,
  input  logic [WORD_W-1:0] inLoadWord,
  output logic              outLoadReady,
  output logic              outLoadDone,
  input  logic              inUnloadStart,
  output logic              outUnloadValid,
  output logic [WORD_W-1:0] outUnloadWord,
  input  logic              inUnloadReady,
  output logic              outBusy,
  output logic [DATA_W-1:0] outData
);

  typedef enum logic [1:0] {IDLE, LOAD, UNLOAD} fsm_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

  fsm_t                              fsm, fsm_nxt;
  logic [CNT_W-1:0]                  cnt;
  logic [DATA_W-1:0]                 stage;
  logic [NUM_WORDS-1:0][WORD_W-1:0]  ubuf;
  logic [DATA_W-1:0]                 data;
  logic                              load_ready;
  logic                              load_done;
  logic                              busy;
  logic                              unl_valid;

  logic              load_acc, load_last, unl_hs, unl_last, start_ok;
  logic [DATA_W-1:0] stage_nxt;

  assign load_acc  = inLoadValid & load_ready;
  assign load_last = load_acc & (cnt == LAST);
  assign unl_hs    = (fsm == UNLOAD) & inUnloadReady;
  assign unl_last  = unl_hs & (cnt == LAST);
  // a load accept in IDLE takes precedence; a coincident start is dropped
  assign start_ok  = (fsm == IDLE) & ~load_acc & inUnloadStart;
  assign stage_nxt = (stage << WORD_W) | DATA_W'(inLoadWord);

  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) fsm <= IDLE;
    else           fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE: begin
        if (load_acc)      fsm_nxt = load_last ? IDLE : LOAD;
        else if (start_ok) fsm_nxt = UNLOAD;
      end
      LOAD:    if (load_last) fsm_nxt = IDLE;
      UNLOAD:  if (unl_last)  fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    unl_valid = 1'b0;
    case (fsm)
      LOAD:    busy = 1'b1;
      UNLOAD: begin
        busy      = 1'b1;
        unl_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // ready is registered from the next state so it rises one cycle after reset
  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) begin
      cnt        <= '0;
      stage      <= '0;
      ubuf       <= '0;
      data       <= '0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      load_ready <= (fsm_nxt != UNLOAD);
      load_done  <= load_last;

      if (load_acc)      cnt <= load_last ? '0 : cnt + CNT_W'(1);
      else if (start_ok) cnt <= '0;
      else if (unl_hs)   cnt <= unl_last ? '0 : cnt + CNT_W'(1);

      if (load_acc) stage <= stage_nxt;

      if (start_ok)    ubuf <= data;
      else if (unl_hs) ubuf <= ubuf << WORD_W;

      // key > serial commit > external > round output
      if (inDataWrKey)      data <= inDataDataKey;
      else if (load_last)   data <= stage_nxt;
      else if (inDataWrExt) data <= inDataDataExt;
      else if (inDataWrInt) data <= inDataDataInt;
    end
  end

  assign outLoadReady   = load_ready;
  assign outLoadDone    = load_done;
  assign outUnloadValid = unl_valid;
  assign outUnloadWord  = ubuf[NUM_WORDS-1];
  assign outBusy        = busy;
  assign outData        = data;

endmodule

// File: tb/tb_noekeon_data_buffer.sv
// Bench for noekeon_data_buffer: directed scenarios plus random traffic,
// compared each cycle against a word-queue transaction model.
module tb_noekeon_data_buffer;

  localparam int DW = 128;
  localparam int WW = 32;
  localparam int NW = DW / WW;

  logic          inClk = 1'b0;
  logic          inResetN = 1'b0;
  logic          inDataWrKey = 0, inDataWrExt = 0, inDataWrInt = 0;
  logic [DW-1:0] inDataDataKey = '0, inDataDataExt = '0, inDataDataInt = '0;
  logic          inLoadValid = 0;
  logic [WW-1:0] inLoadWord = '0;
  logic          outLoadReady, outLoadDone;
  logic          inUnloadStart = 0;
  logic          outUnloadValid;
  logic [WW-1:0] outUnloadWord;
  logic          inUnloadReady = 0;
  logic          outBusy;
  logic [DW-1:0] outData;

  noekeon_data_buffer #(.DATA_W(DW), .WORD_W(WW)) dut (
    .inClk(inClk), .inResetN(inResetN),
    .inDataWrKey(inDataWrKey), .inDataDataKey(inDataDataKey),
    .inDataWrExt(inDataWrExt), .inDataDataExt(inDataDataExt),
    .inDataWrInt(inDataWrInt), .inDataDataInt(inDataDataInt),
    .inLoadValid(inLoadValid), .inLoadWord(inLoadWord),
    .outLoadReady(outLoadReady), .outLoadDone(outLoadDone),
    .inUnloadStart(inUnloadStart), .outUnloadValid(outUnloadValid),
    .outUnloadWord(outUnloadWord), .inUnloadReady(inUnloadReady),
    .outBusy(outBusy), .outData(outData)
  );

  always #5 inClk = ~inClk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // transaction model: words received so far, words still to emit
  logic [WW-1:0] load_q[$];
  logic [WW-1:0] unload_q[$];
  logic [DW-1:0] m_data;
  logic          m_ready, m_done;

  task automatic model_reset();
    load_q.delete();
    unload_q.delete();
    m_data  = '0;
    m_ready = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic model_edge();
    logic          accept, commit, unloading;
    logic [DW-1:0] blk;
    unloading = (unload_q.size() > 0);
    accept    = inLoadValid && m_ready;
    commit    = 1'b0;
    blk       = '0;
    if (accept) begin
      load_q.push_back(inLoadWord);
      if (load_q.size() == NW) begin
        commit = 1'b1;
        foreach (load_q[i]) blk = (blk << WW) | DW'(load_q[i]);
        load_q.delete();
      end
    end else if (!unloading && load_q.size() == 0 && inUnloadStart) begin
      for (int i = 0; i < NW; i++) unload_q.push_back(m_data[DW-1-WW*i -: WW]);
    end
    if (unloading && inUnloadReady) void'(unload_q.pop_front());
    if (inDataWrKey)      m_data = inDataDataKey;
    else if (commit)      m_data = blk;
    else if (inDataWrExt) m_data = inDataDataExt;
    else if (inDataWrInt) m_data = inDataDataInt;
    m_done  = commit;
    m_ready = (unload_q.size() == 0);
  endtask

  task automatic compare();
    chk("data", outData, m_data);
    chk("done", DW'(outLoadDone), DW'(m_done));
    chk("ready", DW'(outLoadReady), DW'(m_ready));
    chk("uvalid", DW'(outUnloadValid), DW'(unload_q.size() > 0));
    chk("busy", DW'(outBusy), DW'(load_q.size() > 0 || unload_q.size() > 0));
    if (unload_q.size() > 0) chk("uword", DW'(outUnloadWord), DW'(unload_q[0]));
  endtask

  task automatic step();
    @(posedge inClk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic quiet();
    inDataWrKey = 0; inDataWrExt = 0; inDataWrInt = 0;
    inLoadValid = 0; inUnloadStart = 0; inUnloadReady = 0;
  endtask

  task automatic async_reset();
    inResetN = 1'b0;
    #1;
    model_reset();
    chk("rst_data", outData, '0);
    chk("rst_busy", DW'(outBusy), '0);
    chk("rst_done", DW'(outLoadDone), '0);
    chk("rst_uvalid", DW'(outUnloadValid), '0);
    chk("rst_uword", DW'(outUnloadWord), '0);
    @(negedge inClk);
    inResetN = 1'b1;
  endtask

  task automatic load_block(input logic [DW-1:0] blk);
    for (int i = 0; i < NW; i++) begin
      inLoadValid = 1;
      inLoadWord  = blk[DW-1-WW*i -: WW];
      step();
    end
    inLoadValid = 0;
  endtask

  logic [DW-1:0] seq_blk;
  logic [3:0]    rdy_pat;

  initial begin
    model_reset();
    #12;
    async_reset();
    step();
    chk("ready_after_rst", DW'(outLoadReady), 1);

    // partial load cut by reset, then a full load
    inLoadValid = 1; inLoadWord = 32'h1111_1111; step();
    inLoadWord = 32'h2222_2222; step();
    inLoadValid = 0;
    @(negedge inClk);
    async_reset();
    step();
    chk("no_done_after_rst", DW'(outLoadDone), 0);
    seq_blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    load_block(seq_blk);
    chk("load_data", outData, seq_blk);
    chk("load_done", DW'(outLoadDone), 1);
    step();
    chk("done_one_cycle", DW'(outLoadDone), 0);

    // gapped load
    for (int i = 0; i < 2 * NW; i++) begin
      inLoadValid = ~i[0];
      inLoadWord  = $urandom;
      step();
    end
    inLoadValid = 0;
    step();

    // unload with backpressure and a round write during the stream
    inDataWrExt = 1; inDataDataExt = {4{32'hA5A5_A5A5}}; step();
    inDataWrExt = 0; inUnloadStart = 1; step();
    inUnloadStart = 0; inDataWrInt = 1; inDataDataInt = '0;
    rdy_pat = 4'b0110;
    for (int i = 0; i < 6; i++) begin
      inUnloadReady = (i < 4) ? ~rdy_pat[3-i] : 1'b1;
      if (outUnloadValid) chk("uword_a5", DW'(outUnloadWord), DW'(32'hA5A5_A5A5));
      step();
      inDataWrInt = 0;
    end
    chk("unload_data0", outData, '0);
    chk("unload_idle", DW'(outUnloadValid), 0);
    quiet();

    // priority: key beats commit beats ext
    inLoadValid = 1;
    for (int i = 0; i < NW; i++) begin
      inLoadWord = 32'h0101_0101 * (i + 1);
      if (i == NW - 1) begin
        inDataWrKey = 1; inDataDataKey = '1;
        inDataWrExt = 1; inDataDataExt = 128'h1234;
      end
      step();
    end
    chk("key_wins", outData, '1);
    chk("key_done", DW'(outLoadDone), 1);
    quiet();
    for (int i = 0; i < NW; i++) begin
      inLoadValid = 1;
      inLoadWord  = 32'hC0DE_0000 + i;
      if (i == NW - 1) begin
        inDataWrExt = 1; inDataDataExt = 128'h5555;
        inDataWrInt = 1; inDataDataInt = 128'h6666;
      end
      step();
    end
    chk("serial_wins", outData, 128'hC0DE0000_C0DE0001_C0DE0002_C0DE0003);
    quiet();

    // simultaneous load and start in idle
    inLoadValid = 1; inUnloadStart = 1; inLoadWord = 32'hDEAD_BEEF; step();
    inUnloadStart = 0;
    chk("sim_busy", DW'(outBusy), 1);
    chk("sim_uvalid", DW'(outUnloadValid), 0);
    for (int i = 1; i < NW; i++) begin
      inLoadWord = $urandom;
      step();
    end
    quiet();
    step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      inLoadValid   = $urandom_range(0, 1);
      inLoadWord    = $urandom;
      inUnloadStart = ($urandom_range(0, 5) == 0);
      inUnloadReady = $urandom_range(0, 1);
      inDataWrKey   = ($urandom_range(0, 15) == 0);
      inDataWrExt   = ($urandom_range(0, 7) == 0);
      inDataWrInt   = ($urandom_range(0, 5) == 0);
      inDataDataKey = {$urandom, $urandom, $urandom, $urandom};
      inDataDataExt = {$urandom, $urandom, $urandom, $urandom};
      inDataDataInt = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
        quiet();
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
